// File: rtl/ccd_timing_gen.sv
// Programmable CCD pixel-clock timing generator: phase counter with shadowed
// per-pixel config, run/graceful-stop control, AFE strobes, pixel and line markers.
module ccd_timing_gen #(
    parameter int         PH_W  = 4,
    parameter int         PIX_W = 12,
    parameter logic [4:0] POL   = 5'b11000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               en,
    input  logic [PH_W-1:0]    cfg_period,
    input  logic [5*PH_W-1:0]  cfg_rise,
    input  logic [5*PH_W-1:0]  cfg_fall,
    input  logic [PIX_W-1:0]   cfg_ppl,
    output logic               f2,
    output logic               rs,
    output logic               cp,
    output logic               shp,
    output logic               shd,
    output logic               pix_stb,
    output logic               line_start,
    output logic [PIX_W-1:0]   pix_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t              state, state_nxt;
    logic [PH_W-1:0]     ph, ph_nxt;
    logic [PIX_W-1:0]    pix_nxt;
    logic [PH_W-1:0]     sh_period;
    logic [5*PH_W-1:0]   sh_rise, sh_fall;
    logic [PIX_W-1:0]    sh_ppl;
    logic [PH_W-1:0]     per_p;
    logic [PIX_W-1:0]    ppl_l;
    logic                last_ph, load, gen;
    logic [4:0]          act, tim_p1;

    // Degenerate settings are clamped so the counters always have a sane wrap point.
    assign per_p   = (sh_period < PH_W'(2)) ? PH_W'(2) : sh_period;
    assign ppl_l   = (sh_ppl == '0) ? PIX_W'(1) : sh_ppl;
    assign last_ph = (ph == per_p - PH_W'(1));
    assign gen     = (state != IDLE);

    function automatic logic in_window(input logic [PH_W-1:0] r, input logic [PH_W-1:0] f,
                                       input logic [PH_W-1:0] p, input logic [PH_W-1:0] cur);
        logic hit;
        if (r == f || r >= p || f > p)
            hit = 1'b0;
        else if (r < f)
            hit = (cur >= r) && (cur < f);
        else
            hit = (cur >= r) || (cur < f);
        return hit;
    endfunction

    always_comb begin
        act = '0;
        for (int i = 0; i < 5; i++)
            act[i] = gen && in_window(sh_rise[i*PH_W +: PH_W], sh_fall[i*PH_W +: PH_W], per_p, ph);
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        pix_nxt   = pix_cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                ph_nxt  = '0;
                pix_nxt = '0;
                load    = 1'b1;
                if (en)
                    state_nxt = RUN;
            end
            RUN, STOP: begin
                if (last_ph) begin
                    ph_nxt  = '0;
                    load    = 1'b1;
                    pix_nxt = (pix_cnt >= ppl_l - PIX_W'(1)) ? '0 : pix_cnt + PIX_W'(1);
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
                // Only the en level on the final phase decides whether another pixel follows.
                if (state == RUN && !en)
                    state_nxt = last_ph ? IDLE : STOP;
                else if (state == STOP && en)
                    state_nxt = RUN;
                else if (state == STOP && last_ph)
                    state_nxt = IDLE;
                if (state_nxt == IDLE)
                    pix_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            ph         <= '0;
            pix_cnt    <= '0;
            tim_p1     <= POL;
            busy       <= 1'b0;
            pix_stb    <= 1'b0;
            line_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            ph         <= ph_nxt;
            pix_cnt    <= pix_nxt;
            tim_p1     <= act ^ POL;
            busy       <= gen;
            pix_stb    <= gen && last_ph;
            line_start <= gen && (ph == '0) && (pix_cnt == '0);
        end
    end

    // Shadow config: captured at start of run and at every phase-0 boundary.
    always_ff @(posedge sys_clk) begin
        if (load) begin
            sh_period <= cfg_period;
            sh_rise   <= cfg_rise;
            sh_fall   <= cfg_fall;
            sh_ppl    <= cfg_ppl;
        end
    end

    assign {shd, shp, cp, rs, f2} = tim_p1;

endmodule

// File: doc/ccd_timing_gen.md
Name: ccd_timing_gen

Overview:
- Parametrised CCD pixel-clock timing generator. It produces the f2/rs/cp/shp/shd analogue-front-end strobes from sys_clk.
- Pixel period and every edge position are runtime programmable; the fixed divide-by-5 table is replaced by a generic phase counter.
- Adds run/stop control with a graceful stop, per-period config shadowing, a pixel strobe, and a line counter.
- Sits between the sensor-control register block and the CCD/AFE pins; pix_stb and line_start drive the capture path.

Parameters:
- PH_W, 4, width of the phase counter and of every phase/period config field.
- PIX_W, 12, width of the pixel counter and of cfg_ppl.
- POL, 5'b11000, idle/active polarity per output, bit order {shd,shp,cp,rs,f2}. 0 = active-high (idle 0); 1 = active-low (idle 1).

Ports:
- sys_clk, in, 1, single clock.
- sys_rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, run request (level).
- cfg_period, in, PH_W, sys_clk cycles per pixel.
- cfg_rise, in, 5*PH_W, assert phase per output, slice i = output i in POL order.
- cfg_fall, in, 5*PH_W, deassert phase per output.
- cfg_ppl, in, PIX_W, pixels per line.
- f2, rs, cp, shp, shd, out, 1 each, registered timing outputs.
- pix_stb, out, 1, one-cycle pulse at the last phase of each pixel.
- line_start, out, 1, one-cycle pulse at phase 0 of pixel 0 of each line.
- pix_cnt, out, PIX_W, index of the current pixel in the line.
- busy, out, 1, high while generating.

Behaviour:
- Reset (async assert, sync release):
  - ph=0, pix_cnt=0, busy=0, pix_stb=0, line_start=0.
  - Each timing output at its idle level (POL bit). With the default POL: shd=1, shp=1, others 0.
- States: IDLE, RUN, STOP.
  - IDLE: outputs idle, ph held 0. en=1 -> RUN; shadow registers load on the same edge; ph=0 and pix_cnt=0.
  - RUN: ph increments by 1 each cycle and wraps from P-1 to 0, where P = max(shadow period, 2).
  - At each wrap: shadow cfg reloads; pix_cnt increments, wrapping from L-1 to 0, where L = max(shadow ppl, 1).
  - en=0 seen in RUN -> STOP.
  - STOP: continues counting exactly as RUN until ph=P-1 completes, then -> IDLE and pix_cnt clears to 0. en=1 seen during STOP returns to RUN with no gap.
- Config changes mid-period have no effect until the next phase 0. The shadow copies all of cfg_period, cfg_rise, cfg_fall and cfg_ppl.
- Active window per output i, with rise r, fall f, phase ph:
  - r<f: active when r<=ph<f.
  - r>f: active when ph>=r or ph<f (wraps across the period boundary).
  - r==f, or r>=P, or f>P: never active (held idle).
  - f==P is legal and means active through ph=P-1.
- Output value = active XOR POL[i], registered. The output therefore reflects the ph of the previous cycle (1-cycle latency), and the same latency applies to pix_stb and line_start.
- busy is registered:
  - 1 from the cycle after the IDLE->RUN transition until the cycle after the final ph=P-1 in STOP.
  - While busy=0, outputs show idle levels only.
- pix_stb = registered (state!=IDLE && ph==P-1).
- line_start = registered (state!=IDLE && ph==0 && pix_cnt==0).
- Arithmetic is unsigned. Counters are exactly PH_W/PIX_W wide with no overflow beyond the clamped bounds.
- Reset mid-operation: all outputs return to the reset values immediately and asynchronously.

Test Plan:
- Default-equivalence: P=5, rise/fall f2=0/3, rs=0/1, cp=1/2, shp=1/2, shd=3/4, default POL, en=1. Required per-period output sequence (f2,rs,cp,shp,shd): (1,1,0,1,1), (1,0,1,0,1), (1,0,0,1,1), (0,0,0,1,0), (0,0,0,1,1), with the first pattern one cycle after ph=0.
- Wrap window: P=8, f2 rise=6 fall=2 -> f2 active at ph 6,7,0,1 every period. Set rise=fall=3 -> f2 stays at its idle level.
- Shadowing: change cfg_period 5->7 at ph=2 -> the current period still ends after ph=4. The next period spans ph 0..6, and pix_stb spacing goes from 5 to 7 cycles.
- Graceful stop and restart: deassert en at ph=1 with P=5 -> phases 2,3,4 complete, then busy drops and outputs go idle. Reassert en in STOP at ph=3 -> continuous run with no idle cycle.
- Line counting and clamps: cfg_ppl=3 -> pix_cnt sequence 0,1,2,0 and line_start once per 3 pix_stb. With cfg_period=0 and cfg_ppl=0, P=2 and L=1 -> pix_stb every 2 cycles and line_start every pixel.
- Async reset: assert sys_rst_n low at ph=2 in RUN -> same cycle, outputs go to reset values (shd=1, shp=1, rest 0), busy=0, pix_cnt=0. Release with en=1 -> restart from ph=0 with line_start.
